instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle sequencer wrapped around the single-cycle datapath (control decode, register file, extender, ALU).
- Owns the PC and fetches instructions from instruction memory over a req/ack handshake.
- Latches the instruction word, then steps through EXEC, optional MEM and WB. Register and memory writes happen only in their own state.
- Computes next PC from nPC_sel, halts on a sentinel opcode, counts retired instructions.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset; bits [1:0] must be 0.
HALT_INST, 32'hFFFFFFFF, instruction word that sends the FSM to HALT.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address, equals pc
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
inst  output  32  latched instruction, drives datapath/control
nPC_sel  input  1  branch taken (from control)
RegWr  input  1  register write request (from control)
MemWr  input  1  store (from control)
MemtoReg  input  1  load (from control)
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write enable, valid with dmem_req
dmem_ack  input  1  data access complete
reg_wr_en  output  1  gated register-file write strobe
pc  output  32  current program counter
halted  output  1  FSM in HALT
retired  output  CNT_WIDTH  count of completed instructions

Behaviour:
- Reset: rst_n sampled low at an edge puts the block in its reset state at that edge, from any state, including mid-handshake.
  - state=IDLE, pc=RESET_PC, inst=0, retired=0.
  - imem_req, dmem_req, dmem_we, reg_wr_en and halted all 0.
  - Outstanding memory transactions are abandoned; a late ack is ignored because req is 0.
- States: IDLE, FETCH, EXEC, MEM, WB, HALT. All outputs are decoded from registered state and registered data. No input-to-output combinational paths except imem_addr=pc.
- IDLE: always -> FETCH next cycle.
- FETCH:
  - imem_req=1 and held until imem_ack is sampled high.
  - On ack, latch inst<=imem_rdata.
  - If imem_rdata==HALT_INST -> HALT, otherwise -> EXEC.
- EXEC: one cycle for control/ALU settle.
  - Latch nPC_sel, RegWr, MemWr and MemtoReg into internal registers.
  - If MemWr|MemtoReg -> MEM, otherwise -> WB.
- MEM:
  - dmem_req=1 and dmem_we=latched MemWr, both held until dmem_ack.
  - On ack -> WB. The loaded data path is external (MemtoReg mux).
- WB:
  - reg_wr_en=latched RegWr for exactly this one cycle.
  - retired increments by 1, wrapping mod 2^CNT_WIDTH.
  - pc update: latched nPC_sel ? pc+4+(sext(inst[15:0])<<2) : pc+4. All arithmetic is 32-bit mod 2^32; pc[1:0] is forced to 00.
  - -> FETCH.
- HALT:
  - halted=1, and all req/strobe outputs are 0.
  - pc stays at the halt instruction's address and retired is unchanged (the halt word does not retire).
  - Only rst_n exits HALT.
- Acks: imem_ack outside FETCH and dmem_ack outside MEM are ignored. An ack in the same cycle as req rising is accepted, giving a 1-cycle FETCH/MEM.
- Latency with zero-wait memory: non-memory instruction = 3 cycles (FETCH, EXEC, WB). Load/store = 4 cycles. Each wait cycle on an ack adds 1.
- reg_wr_en and dmem_we are never both high. reg_wr_en is never high outside WB.

Test Plan:
- Reset/boot: hold rst_n=0 for 3 cycles, release -> 1 cycle IDLE, then imem_req=1, imem_addr=0. All outputs are 0 during reset.
- R-type add, zero-wait: imem_rdata=32'h00221820, ack immediate, RegWr=1 -> states FETCH/EXEC/WB; reg_wr_en high 1 cycle; pc 0->4; retired=1; dmem_req stays 0.
- Fetch wait + load:
  - imem_ack delayed 4 cycles -> imem_req held 5 cycles with imem_addr stable.
  - Instruction is lw (MemtoReg=1, RegWr=1) with dmem_ack delayed 2 cycles -> dmem_req held 3 cycles with dmem_we=0, then reg_wr_en pulses.
- Store and branch:
  - sw at pc=0x8 -> dmem_we=1 in MEM, reg_wr_en=0, pc=0xC.
  - beq with nPC_sel=1, inst[15:0]=16'hFFFF at pc=0x10 -> pc=0x10.
  - inst[15:0]=16'h0003 at pc=0x10 -> pc=0x20.
- Halt: imem_rdata=32'hFFFFFFFF at pc=0x14 -> halted=1; pc stays 0x14; retired unchanged; further acks ignored for 20 cycles.
- Reset mid-MEM: assert rst_n=0 while dmem_req=1 -> next edge dmem_req=0, pc=RESET_PC, retired=0. A dmem_ack after reset release causes no transition.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over a req/ack handshake,
// and steps each instruction through EXEC, optional MEM and WB around a
// single-cycle datapath. Halts on a sentinel instruction word.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          inst,
    input  logic                 nPC_sel,
    input  logic                 RegWr,
    input  logic                 MemWr,
    input  logic                 MemtoReg,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 reg_wr_en,
    output logic [31:0]          pc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          inst_q, inst_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 npc_sel_q, npc_sel_d;
    logic                 reg_wr_q, reg_wr_d;
    logic                 mem_wr_q, mem_wr_d;
    logic                 imem_req_q, imem_req_d;
    logic                 dmem_req_q, dmem_req_d;
    logic                 dmem_we_q, dmem_we_d;
    logic                 reg_wr_en_q, reg_wr_en_d;
    logic                 halted_q, halted_d;

    logic [31:0]          seq_pc;
    logic [31:0]          br_off;
    logic [31:0]          next_pc;

    // Sequential and branch-target PC; the word offset is sign-extended and shifted by 2
    always_comb begin
        seq_pc  = pc_q + 32'd4;
        br_off  = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
        next_pc = npc_sel_q ? (seq_pc + br_off) : seq_pc;
        next_pc = {next_pc[31:2], 2'b00};
    end

    // Next-state, datapath latches and registered output decode of the next state
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        npc_sel_d = npc_sel_q;
        reg_wr_d  = reg_wr_q;
        mem_wr_d  = mem_wr_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = (imem_rdata == HALT_INST) ? S_HALT : S_EXEC;
                end
            end
            S_EXEC: begin
                npc_sel_d = nPC_sel;
                reg_wr_d  = RegWr;
                mem_wr_d  = MemWr;
                state_d   = (MemWr | MemtoReg) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d      = next_pc;
                retired_d = retired_q + CNT_WIDTH'(1);
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_req_d  = (state_d == S_FETCH);
        dmem_req_d  = (state_d == S_MEM);
        dmem_we_d   = (state_d == S_MEM) && mem_wr_d;
        reg_wr_en_d = (state_d == S_WB) && reg_wr_d;
        halted_d    = (state_d == S_HALT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= 32'd0;
            retired_q   <= '0;
            npc_sel_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            reg_wr_en_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            retired_q   <= retired_d;
            npc_sel_q   <= npc_sel_d;
            reg_wr_q    <= reg_wr_d;
            mem_wr_q    <= mem_wr_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            reg_wr_en_q <= reg_wr_en_d;
            halted_q    <= halted_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign reg_wr_en = reg_wr_en_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a dynamic instruction trace drives
// randomised-latency memory responders, a reference walk of the trace fills
// expectation queues, and a monitor pops and compares on DUT events.
module tb_instr_sequencer;

    localparam int unsigned CW       = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] HALT_W   = 32'hFFFF_FFFF;

    logic          clk;
    logic          rst_n;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   inst;
    logic          nPC_sel;
    logic          RegWr;
    logic          MemWr;
    logic          MemtoReg;
    logic          dmem_req;
    logic          dmem_we;
    logic          dmem_ack;
    logic          reg_wr_en;
    logic [31:0]   pc;
    logic          halted;
    logic [CW-1:0] retired;

    instr_sequencer #(
        .RESET_PC (RST_PC),
        .HALT_INST(HALT_W),
        .CNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst      (inst),
        .nPC_sel   (nPC_sel),
        .RegWr     (RegWr),
        .MemWr     (MemWr),
        .MemtoReg  (MemtoReg),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .reg_wr_en (reg_wr_en),
        .pc        (pc),
        .halted    (halted),
        .retired   (retired)
    );

    typedef struct {
        logic [31:0] word;
        bit          npc;
        bit          regwr;
        bit          memwr;
        bit          memtoreg;
        bit          halt;
        int          iw;
        int          dw;
    } entry_t;

    typedef struct {
        logic [CW-1:0] ret;
        logic [31:0]   pc;
        int            lat;
    } ret_t;

    entry_t      trace[$];
    logic [31:0] exp_fetch[$];
    bit          exp_mem[$];
    logic [31:0] exp_wb[$];
    ret_t        exp_ret[$];
    logic [31:0] exp_halt[$];

    int n_checks = 0;
    int n_err    = 0;
    int cur_k    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got an event, expected none (t=%0t)", name, $time);
    endtask

    function automatic entry_t mk(input logic [31:0] w, input bit npc, input bit rw,
                                  input bit mw, input bit ml, input int iw, input int dw);
        entry_t e;
        e.word = w; e.npc = npc; e.regwr = rw; e.memwr = mw; e.memtoreg = ml;
        e.halt = (w == HALT_W); e.iw = iw; e.dw = dw;
        return e;
    endfunction

    function automatic entry_t rand_entry(input bit allow_mem);
        entry_t e;
        int     k;
        e.word = $urandom;
        if (e.word == HALT_W) e.word = 32'h0;
        e.npc      = ($urandom_range(0, 1) == 1);
        e.regwr    = ($urandom_range(0, 1) == 1);
        k          = allow_mem ? $urandom_range(0, 3) : 0;
        e.memwr    = (k == 2) || (k == 3);
        e.memtoreg = (k == 1) || (k == 3);
        e.halt     = 1'b0;
        e.iw       = $urandom_range(0, 3);
        e.dw       = $urandom_range(0, 3);
        return e;
    endfunction

    // Reference walk of the dynamic trace: what each instruction must produce
    task automatic model_trace();
        logic [31:0]   mpc;
        logic [CW-1:0] r;
        int            off;
        bit            is_mem;
        ret_t          rt;
        exp_fetch.delete(); exp_mem.delete(); exp_wb.delete();
        exp_ret.delete();   exp_halt.delete();
        mpc = RST_PC;
        r   = '0;
        foreach (trace[k]) begin
            exp_fetch.push_back(mpc);
            if (trace[k].halt) begin
                exp_halt.push_back(mpc);
                break;
            end
            is_mem = trace[k].memwr || trace[k].memtoreg;
            if (is_mem) exp_mem.push_back(trace[k].memwr);
            if (trace[k].regwr) exp_wb.push_back(mpc);
            off = trace[k].npc ? int'($signed(trace[k].word[15:0])) * 4 : 0;
            mpc = mpc + 32'(4 + off);
            mpc[1:0] = 2'b00;
            r = r + CW'(1);
            rt.ret = r;
            rt.pc  = mpc;
            rt.lat = 3 + trace[k].iw + (is_mem ? 1 + trace[k].dw : 0);
            exp_ret.push_back(rt);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"},  32'({imem_req, dmem_req, dmem_we, reg_wr_en, halted}), 32'd0);
        chk({tag, "_pc"},   pc, RST_PC);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_ret"},  32'(retired), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_drained"}, 32'(exp_fetch.size() + exp_mem.size() + exp_wb.size()
                                   + exp_ret.size() + exp_halt.size()), 32'd0);
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
        chk({tag, "_halt_reached"}, 32'(halted), 32'd1);
    endtask

    // Instruction memory + control responder, served in dynamic trace order
    initial begin
        int wcnt;
        int fk;
        bit busy;
        bit real_ack;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        nPC_sel = 1'b0; RegWr = 1'b0; MemWr = 1'b0; MemtoReg = 1'b0;
        wcnt = 0; fk = 0; busy = 1'b0; real_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                imem_ack = 1'b0; busy = 1'b0; real_ack = 1'b0; fk = 0;
            end else begin
                if (real_ack) begin
                    real_ack = 1'b0; busy = 1'b0; fk++;
                end
                imem_ack = 1'b0;
                if (imem_req && fk < trace.size()) begin
                    if (!busy) begin
                        busy = 1'b1;
                        wcnt = trace[fk].iw;
                    end
                    if (wcnt == 0) begin
                        imem_ack   = 1'b1;
                        real_ack   = 1'b1;
                        imem_rdata = trace[fk].word;
                        nPC_sel    = trace[fk].npc;
                        RegWr      = trace[fk].regwr;
                        MemWr      = trace[fk].memwr;
                        MemtoReg   = trace[fk].memtoreg;
                        cur_k      = fk;
                    end else begin
                        wcnt--;
                    end
                end else if (!imem_req && $urandom_range(0, 3) == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = HALT_W;
                end
            end
        end
    end

    // Data memory responder; stray acks while idle must be ignored by the DUT
    initial begin
        int dcnt;
        bit dbusy;
        dmem_ack = 1'b0; dcnt = 0; dbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dmem_ack = 1'b0; dbusy = 1'b0;
            end else begin
                dmem_ack = 1'b0;
                if (dmem_req) begin
                    if (!dbusy) begin
                        dbusy = 1'b1;
                        dcnt  = trace[cur_k].dw;
                    end
                    if (dcnt == 0) begin
                        dmem_ack = 1'b1;
                        dbusy    = 1'b0;
                    end else begin
                        dcnt--;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    dmem_ack = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expectations on DUT output events and compares
    initial begin
        bit            p_ireq, p_dreq, p_wr, p_halt;
        logic [31:0]   p_addr, halt_pc;
        logic [CW-1:0] p_ret, halt_ret;
        int            cyc, t0;
        ret_t          rt;
        p_ireq = 0; p_dreq = 0; p_wr = 0; p_halt = 0;
        p_addr = '0; halt_pc = '0; p_ret = '0; halt_ret = '0;
        cyc = 0; t0 = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                p_ireq = 0; p_dreq = 0; p_wr = 0; p_halt = 0; p_ret = '0;
            end else begin
                if (retired != p_ret) begin
                    if (exp_ret.size() == 0) unexpected("retire");
                    else begin
                        rt = exp_ret.pop_front();
                        chk("retired_count", 32'(retired), 32'(rt.ret));
                        chk("retire_pc", pc, rt.pc);
                        chk("latency", 32'(cyc - t0), 32'(rt.lat));
                    end
                end
                if (imem_req && !p_ireq) begin
                    t0 = cyc;
                    if (exp_fetch.size() == 0) unexpected("fetch");
                    else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
                end
                if (imem_req && p_ireq) chk("fetch_addr_stable", imem_addr, p_addr);
                if (dmem_req && !p_dreq) begin
                    if (exp_mem.size() == 0) unexpected("dmem");
                    else chk("dmem_we", 32'(dmem_we), 32'(exp_mem.pop_front()));
                end
                if (reg_wr_en) begin
                    if (exp_wb.size() == 0) unexpected("reg_wr_en");
                    else chk("reg_wr_pc", pc, exp_wb.pop_front());
                    chk("reg_wr_single", 32'(p_wr), 32'd0);
                end
                if (reg_wr_en && dmem_we) unexpected("wr_and_we");
                if (halted && !p_halt) begin
                    if (exp_halt.size() == 0) unexpected("halt");
                    else chk("halt_pc", pc, exp_halt.pop_front());
                    halt_pc  = pc;
                    halt_ret = retired;
                end
                if (halted && p_halt) begin
                    chk("halt_quiet_ctl", 32'({imem_req, dmem_req, dmem_we, reg_wr_en, retired}),
                        32'({4'b0000, halt_ret}));
                    chk("halt_quiet_pc", pc, halt_pc);
                end
                p_ireq = imem_req; p_dreq = dmem_req; p_wr = reg_wr_en;
                p_halt = halted;   p_addr = imem_addr; p_ret = retired;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Main sequence: directed program, random program, reset during MEM
    initial begin
        rst_n = 1'b0;
        trace.delete();
        trace.push_back(mk(32'h0022_1820, 0, 1, 0, 0, 0, 0)); // add   @0x00 -> 0x04
        trace.push_back(mk(32'h8C22_0004, 0, 1, 0, 1, 4, 2)); // lw    @0x04 -> 0x08
        trace.push_back(mk(32'hAC22_0008, 0, 0, 1, 0, 1, 0)); // sw    @0x08 -> 0x0C
        trace.push_back(mk(32'h0000_0020, 0, 0, 0, 0, 0, 0)); // alu   @0x0C -> 0x10
        trace.push_back(mk(32'h1022_FFFF, 1, 0, 0, 0, 0, 0)); // beq-1 @0x10 -> 0x10
        trace.push_back(mk(32'h1022_0003, 1, 0, 0, 0, 2, 0)); // beq+3 @0x10 -> 0x20
        trace.push_back(mk(32'h1022_FFFC, 1, 0, 0, 0, 0, 0)); // beq-4 @0x20 -> 0x14
        trace.push_back(mk(HALT_W,        0, 0, 0, 0, 1, 0)); // halt  @0x14
        model_trace();
        repeat (3) @(negedge clk);
        check_reset("boot");
        rst_n = 1'b1;
        wait_halt("directed");
        repeat (20) @(negedge clk);
        check_drained("directed");

        // Random program long enough to wrap the narrow retire counter
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("rst_halt");
        trace.delete();
        for (int i = 0; i < 40; i++) trace.push_back(rand_entry(1'b1));
        trace.push_back(mk(HALT_W, 0, 0, 0, 0, $urandom_range(0, 3), 0));
        model_trace();
        @(negedge clk);
        rst_n = 1'b1;
        wait_halt("random");
        repeat (5) @(negedge clk);
        check_drained("random");

        // Reset while a long data access is outstanding
        rst_n = 1'b0;
        @(negedge clk);
        trace.delete();
        for (int i = 0; i < 3; i++) trace.push_back(rand_entry(1'b0));
        trace.push_back(mk(32'h8C22_0010, 0, 1, 0, 1, 0, 40));
        trace.push_back(mk(HALT_W, 0, 0, 0, 0, 0, 0));
        model_trace();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 500 && !(dmem_req && retired == CW'(3)); i++) @(negedge clk);
        chk("mid_mem_reached", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid_mem");
        trace.delete();
        for (int i = 0; i < 15; i++) trace.push_back(rand_entry(1'b1));
        trace.push_back(mk(HALT_W, 0, 0, 0, 0, 2, 0));
        model_trace();
        @(negedge clk);
        rst_n = 1'b1;
        wait_halt("after_reset");
        repeat (5) @(negedge clk);
        check_drained("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
